fetch_prefetch_queue: RTL and testbench
=======================================

Name: fetch_prefetch_queue

Overview:
Instruction prefetch stage that sits directly upstream of the IF/ID pipeline register. It owns the fetch PC and issues word requests to a variable-latency instruction memory over a req/ack handshake. Returned words are buffered in a small FIFO, and the head entry is presented to the decode register as instruction/PCF/PCPlus4F. It obeys StallF from the hazard unit and redirects on PCSrcE/PCTargetE from the execute stage.

Parameters:
DEPTH, 4, queue entries (power of two, >=2)
RESET_PC, 32'h0000_0000, fetch address after reset
NOP_INSTR, 32'h0000_0013, instruction driven when queue empty (addi x0,x0,0)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
imem_req  out  1  request valid; held until imem_ack
imem_addr  out  32  word address of request; stable while imem_req=1
imem_ack  in  1  response valid; imem_rdata valid this cycle; may coincide with first req cycle
imem_rdata  in  32  fetched instruction
StallF  in  1  hazard unit: do not consume head this cycle
PCSrcE  in  1  taken branch/jump redirect
PCTargetE  in  32  redirect target
instr_valid  out  1  head entry valid (queue non-empty)
instruction  out  32  head instruction, NOP_INSTR when empty
PCF  out  32  head PC, 0 when empty
PCPlus4F  out  32  PCF+4 (modulo 2^32), 4 when empty

Behaviour:
- Reset (async): queue count=0, rd/wr pointers=0, fetch_pc=RESET_PC, state=IDLE, imem_req=0, instr_valid=0, instruction=NOP_INSTR, PCF=0, PCPlus4F=4. An in-flight memory request is abandoned; the memory is reset by the same rst.
- FSM states: IDLE, REQ, DROP.
- IDLE: if PCSrcE=0 and count<DEPTH, go to REQ with imem_addr=fetch_pc. If PCSrcE=1, fetch_pc<=PCTargetE and stay IDLE.
- REQ: imem_req=1 and imem_addr=fetch_pc (combinational from state).
  - On imem_ack with PCSrcE=0: push {fetch_pc, imem_rdata} and set fetch_pc<=fetch_pc+4.
  - After that ack, stay in REQ (back-to-back) if (count after this cycle's push and pop) < DEPTH; otherwise go to IDLE.
  - Peak throughput: 1 instruction/cycle with zero-latency ack.
- REQ, no ack, PCSrcE=1: flush queue, fetch_pc<=PCTargetE, go to DROP.
- REQ, ack and PCSrcE=1 in the same cycle: discard the data, flush queue, fetch_pc<=PCTargetE, go to IDLE.
- DROP: imem_req stays 1 with the old address (saved in drop_addr) until imem_ack. The acked data is discarded, then go to IDLE.
  - A further PCSrcE in DROP only updates fetch_pc.
- Pop: when instr_valid=1, StallF=0 and PCSrcE=0, rd_ptr advances and count decrements.
- Flush: PCSrcE=1 sets count=0 and rd_ptr=wr_ptr on that edge, regardless of StallF. Any push or pop in that cycle is cancelled.
- Push and pop in the same cycle: count is unchanged, both pointers advance.
- A push into a full queue must not occur. Requests are issued only when space is guaranteed; the implementation asserts this.
- Pointers wrap modulo DEPTH. fetch_pc and PCPlus4F wrap modulo 2^32.
- Outputs are registered/FIFO-read only; there is no combinational path from imem_rdata to instruction. Latency from ack to instr_valid is one cycle.
- StallF=1 holds the head outputs stable. Fetching continues until the queue is full.

Test Plan:
1. Reset, then ack every req in its first cycle with rdata=0x100+addr: instr_valid rises the cycle after the first ack, PCF sequence 0,4,8,..., instruction=0x100,0x104,...; one pop/cycle sustained.
2. StallF held high for 10 cycles: queue reaches 4 entries, imem_req drops to 0 after the 4th ack, and the head stays at the same PCF/instruction. On release, the 4 entries drain in order and requests resume.
3. ack latency 3 cycles, PCSrcE=1 (PCTargetE=0x80) on the 1st wait cycle: req stays high with old addr, the returned word is never seen at the outputs, queue is empty, and the next request has imem_addr=0x80.
4. ack and PCSrcE=1 (target 0x200) in the same cycle: the data is dropped, instr_valid=0 next cycle, the next req uses addr 0x200, and the following output has PCF=0x200, PCPlus4F=0x204.
5. rst asserted asynchronously mid-REQ with 2 entries queued: outputs immediately go to instr_valid=0, instruction=0x13, imem_req=0. After release the first req has addr=RESET_PC.
6. fetch_pc=0xFFFF_FFFC fetched and popped: PCPlus4F=0x0000_0000 and the next request address is 0x0000_0000.

Source files
------------

// File: rtl/fetch_prefetch_queue.sv
// Instruction prefetch queue feeding the IF/ID register: owns the fetch PC and buffers fetched words.
// Latency: an imem_ack becomes visible at the head one cycle later; no combinational rdata->instruction path.
// Backpressure: StallF holds the head; new requests are issued only while a queue slot is guaranteed free.
//
// Ports:
//   clk, rst                 rising-edge clock, asynchronous active-high reset
//   imem_req/imem_addr       word request to instruction memory, held with a stable address until imem_ack
//   imem_ack/imem_rdata      response handshake; data is valid in the ack cycle (may be the first req cycle)
//   StallF                   hazard unit stall: head is not consumed this cycle
//   PCSrcE/PCTargetE         execute-stage redirect: flushes the queue and reloads the fetch PC
//   instr_valid              queue non-empty
//   instruction/PCF/PCPlus4F head entry, or NOP_INSTR / 0 / 4 when empty
module fetch_prefetch_queue #(
   parameter int unsigned DEPTH     = 4,
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic        StallF,
   input  logic        PCSrcE,
   input  logic [31:0] PCTargetE,
   output logic        instr_valid,
   output logic [31:0] instruction,
   output logic [31:0] PCF,
   output logic [31:0] PCPlus4F
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DROP = 2'd2
   } fetchState;

   fetchState     state;
   fetchState     nextState;

   logic [31:0]   fetchPc;
   logic [31:0]   fetchPcNext;
   logic [31:0]   dropAddr;
   logic          loadDrop;

   logic [31:0]   pcMem    [DEPTH];
   logic [31:0]   instrMem [DEPTH];
   logic [PW-1:0] rdPtr;
   logic [PW-1:0] wrPtr;
   logic [CW-1:0] count;
   logic [CW-1:0] countNext;

   logic          push;
   logic          pop;

   // A redirect cancels both the push of the returning word and the pop of the head.
   assign push = (state == REQ) && imem_ack && !PCSrcE;
   assign pop  = instr_valid && !StallF && !PCSrcE;

   always_comb begin
      countNext = count;
      if (PCSrcE) begin
         countNext = '0;
      end else begin
         case ({push, pop})
            2'b10:   countNext = count + CW'(1);
            2'b01:   countNext = count - CW'(1);
            default: countNext = count;
         endcase
      end
   end

   // ---------------------------------------------------------------
   // Request FSM
   // ---------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   always_comb begin
      nextState   = state;
      fetchPcNext = fetchPc;
      loadDrop    = 1'b0;
      imem_req    = 1'b0;
      imem_addr   = fetchPc;
      case (state)
         IDLE: begin
            if (PCSrcE) begin
               fetchPcNext = PCTargetE;
            end else if (count < FULL) begin
               nextState = REQ;
            end
         end
         REQ: begin
            imem_req = 1'b1;
            if (PCSrcE) begin
               fetchPcNext = PCTargetE;
               if (imem_ack) begin
                  // Word arrived together with the redirect: simply drop it.
                  nextState = IDLE;
               end else begin
                  // The memory still owes us a word for the old address; wait it out.
                  nextState = DROP;
                  loadDrop  = 1'b1;
               end
            end else if (imem_ack) begin
               fetchPcNext = fetchPc + 32'd4;
               // Chain the next request only if a slot is certain to be free when it returns.
               nextState   = (countNext < FULL) ? REQ : IDLE;
            end
         end
         DROP: begin
            imem_req  = 1'b1;
            imem_addr = dropAddr;
            if (PCSrcE) begin
               fetchPcNext = PCTargetE;
            end
            if (imem_ack) begin
               nextState = IDLE;
            end
         end
         default: begin
            nextState = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetchPc  <= RESET_PC;
         dropAddr <= '0;
      end else begin
         fetchPc <= fetchPcNext;
         if (loadDrop) begin
            dropAddr <= fetchPc;
         end
      end
   end

   // ---------------------------------------------------------------
   // Queue storage and pointers
   // ---------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (push) begin
         pcMem[wrPtr]    <= fetchPc;
         instrMem[wrPtr] <= imem_rdata;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdPtr <= '0;
         wrPtr <= '0;
         count <= '0;
      end else begin
         count <= countNext;
         if (PCSrcE) begin
            // Flush: everything between rdPtr and wrPtr is discarded.
            rdPtr <= wrPtr;
         end else begin
            if (push) begin
               wrPtr <= wrPtr + PW'(1);
            end
            if (pop) begin
               rdPtr <= rdPtr + PW'(1);
            end
         end
      end
   end

   // ---------------------------------------------------------------
   // Head outputs (register/FIFO read only)
   // ---------------------------------------------------------------
   always_comb begin
      instr_valid = (count != '0);
      instruction = NOP_INSTR;
      PCF         = 32'd0;
      if (instr_valid) begin
         instruction = instrMem[rdPtr];
         PCF         = pcMem[rdPtr];
      end
      PCPlus4F = PCF + 32'd4;
   end

   // ---------------------------------------------------------------
   // Protocol and capacity checks
   // ---------------------------------------------------------------
   pushNeverFull: assert property (@(posedge clk) disable iff (rst) push |-> (count < FULL));

   reqHeldUntilAck: assert property (@(posedge clk) disable iff (rst)
      (imem_req && !imem_ack) |=> (imem_req && $stable(imem_addr)));

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Self-checking bench for fetch_prefetch_queue: directed scenarios followed by randomized traffic.
// A behavioural memory answers requests with configurable latency; a queue-based model predicts outputs.
// The model tracks fetch address, outstanding/abandoned requests and queue contents at transaction level.
module tb_fetch_prefetch_queue;

   localparam int          DEPTH     = 4;
   localparam logic [31:0] RESET_PC  = 32'h0000_0000;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack   = 1'b0;
   logic [31:0] imem_rdata = 32'd0;
   logic        StallF     = 1'b0;
   logic        PCSrcE     = 1'b0;
   logic [31:0] PCTargetE  = 32'd0;
   logic        instr_valid;
   logic [31:0] instruction;
   logic [31:0] PCF;
   logic [31:0] PCPlus4F;

   fetch_prefetch_queue #(
      .DEPTH    (DEPTH),
      .RESET_PC (RESET_PC),
      .NOP_INSTR(NOP_INSTR)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ack   (imem_ack),
      .imem_rdata (imem_rdata),
      .StallF     (StallF),
      .PCSrcE     (PCSrcE),
      .PCTargetE  (PCTargetE),
      .instr_valid(instr_valid),
      .instruction(instruction),
      .PCF        (PCF),
      .PCPlus4F   (PCPlus4F)
   );

   always #5 clk = ~clk;

   int passCnt  = 0;
   int totalCnt = 0;

   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
      totalCnt++;
      if (got === exp) begin
         passCnt++;
      end else begin
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      logic [31:0] pc;
      logic [31:0] ins;
   } entryT;

   entryT       modelQ[$];
   logic [31:0] expPc      = RESET_PC;
   logic [31:0] heldAddr   = 32'd0;
   bit          outstanding = 1'b0;
   bit          dropping    = 1'b0;
   int          waitLeft    = 0;
   int          latMin      = 0;
   int          latMax      = 0;
   bit          lastRedir;
   bit          lastNewReq;
   logic [31:0] lastNewAddr;

   function automatic logic [31:0] memData(input logic [31:0] a);
      return a + 32'h100;
   endfunction

   // One clock cycle: drive memory/hazard inputs, check outputs, advance the model past the next edge.
   // redirMode: 0 none, 1 always, 2 only on the first wait cycle of a new request, 3 only with a live ack.
   task automatic stepCycle(input bit stall, input int redirMode, input logic [31:0] tgt);
      bit          newReq;
      bit          ackNow;
      bit          redir;
      logic [31:0] reqAddr;
      @(posedge clk);
      #1;
      newReq = imem_req && !outstanding;
      if (newReq) begin
         waitLeft = $urandom_range(latMax, latMin);
      end
      ackNow = imem_req && (waitLeft == 0);
      if (imem_req && !ackNow) begin
         waitLeft--;
      end
      imem_ack   = ackNow;
      imem_rdata = ackNow ? memData(imem_addr) : $urandom();
      redir      = (redirMode == 1) ||
                   (redirMode == 2 && newReq && !ackNow) ||
                   (redirMode == 3 && ackNow && !dropping);
      PCSrcE     = redir;
      PCTargetE  = tgt;
      StallF     = stall;
      lastRedir   = redir;
      lastNewReq  = newReq;
      lastNewAddr = imem_addr;
      #3;
      if (modelQ.size() == 0) begin
         checkVal("validEmpty", 32'(instr_valid), 32'd0);
         checkVal("nopInstr", instruction, NOP_INSTR);
         checkVal("pcfEmpty", PCF, 32'd0);
         checkVal("pc4Empty", PCPlus4F, 32'd4);
      end else begin
         checkVal("validHead", 32'(instr_valid), 32'd1);
         checkVal("instr", instruction, modelQ[0].ins);
         checkVal("pcf", PCF, modelQ[0].pc);
         checkVal("pcPlus4", PCPlus4F, modelQ[0].pc + 32'd4);
      end
      if (outstanding) begin
         checkVal("reqHeld", 32'(imem_req), 32'd1);
         checkVal("addrStable", imem_addr, heldAddr);
         reqAddr = heldAddr;
      end else begin
         if (imem_req) begin
            checkVal("reqAddr", imem_addr, expPc);
         end
         reqAddr = expPc;
      end
      // Effects of the coming clock edge.
      if (modelQ.size() != 0 && !stall && !redir) begin
         void'(modelQ.pop_front());
      end
      if (ackNow) begin
         if (!dropping && !redir) begin
            if (modelQ.size() >= DEPTH) begin
               checkVal("overflow", 32'(modelQ.size()), 32'(DEPTH - 1));
            end
            modelQ.push_back('{pc: reqAddr, ins: memData(reqAddr)});
            expPc = reqAddr + 32'd4;
         end
         outstanding = 1'b0;
         dropping    = 1'b0;
      end else if (imem_req) begin
         outstanding = 1'b1;
         heldAddr    = reqAddr;
         if (redir) begin
            dropping = 1'b1;
         end
      end
      if (redir) begin
         modelQ.delete();
         expPc = tgt;
      end
   endtask

   task automatic waitNewReq(input string tag, input bit stall, input logic [31:0] expAddr);
      bit seen = 1'b0;
      for (int i = 0; i < 30 && !seen; i++) begin
         stepCycle(stall, 0, 32'd0);
         seen = lastNewReq;
      end
      checkVal({tag, "_seen"}, 32'(seen), 32'd1);
      if (seen) begin
         checkVal(tag, lastNewAddr, expAddr);
      end
   endtask

   task automatic applyReset();
      #2;
      rst      = 1'b1;
      imem_ack = 1'b0;
      StallF   = 1'b0;
      PCSrcE   = 1'b0;
      #1;
      checkVal("rstValid", 32'(instr_valid), 32'd0);
      checkVal("rstInstr", instruction, NOP_INSTR);
      checkVal("rstPcf", PCF, 32'd0);
      checkVal("rstPc4", PCPlus4F, 32'd4);
      checkVal("rstReq", 32'(imem_req), 32'd0);
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b0;
      modelQ.delete();
      expPc       = RESET_PC;
      outstanding = 1'b0;
      dropping    = 1'b0;
      waitLeft    = 0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] hold;
      logic [31:0] prevPc;
      bit          seen;
      logic [31:0] tgt;
      int          mode;

      // 1: zero-latency streaming
      latMin = 0;
      latMax = 0;
      applyReset();
      stepCycle(0, 0, 32'd0);
      checkVal("t1_firstReq", 32'(lastNewReq), 32'd1);
      checkVal("t1_firstAddr", lastNewAddr, RESET_PC);
      stepCycle(0, 0, 32'd0);
      checkVal("t1_validRise", 32'(instr_valid), 32'd1);
      checkVal("t1_pcf0", PCF, 32'd0);
      checkVal("t1_instr0", instruction, 32'h100);
      prevPc = PCF;
      for (int i = 0; i < 8; i++) begin
         stepCycle(0, 0, 32'd0);
         checkVal("t1_stream", PCF, prevPc + 32'd4);
         prevPc = PCF;
      end

      // 2: stall fills the queue, then drain
      stepCycle(1, 0, 32'd0);
      hold = PCF;
      for (int i = 0; i < 9; i++) begin
         stepCycle(1, 0, 32'd0);
      end
      checkVal("t2_headHeld", PCF, hold);
      checkVal("t2_reqOff", 32'(imem_req), 32'd0);
      checkVal("t2_full", 32'(modelQ.size()), 32'(DEPTH));
      waitNewReq("t2_resume", 0, hold + 32'd16);
      for (int i = 0; i < 4; i++) begin
         stepCycle(0, 0, 32'd0);
      end

      // 3: redirect while a 3-cycle request is pending
      latMin = 3;
      latMax = 3;
      seen   = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         stepCycle(0, 2, 32'h80);
         seen = lastRedir;
      end
      checkVal("t3_redirected", 32'(seen), 32'd1);
      stepCycle(0, 0, 32'd0);
      checkVal("t3_flushed", 32'(instr_valid), 32'd0);
      waitNewReq("t3_newAddr", 0, 32'h80);

      // 4: ack and redirect in the same cycle
      latMin = 0;
      latMax = 0;
      seen   = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         stepCycle(0, 3, 32'h200);
         seen = lastRedir;
      end
      checkVal("t4_redirected", 32'(seen), 32'd1);
      stepCycle(0, 0, 32'd0);
      checkVal("t4_dropped", 32'(instr_valid), 32'd0);
      waitNewReq("t4_addr", 0, 32'h200);
      stepCycle(1, 0, 32'd0);
      checkVal("t4_pcf", PCF, 32'h200);
      checkVal("t4_pc4", PCPlus4F, 32'h204);

      // 5: asynchronous reset with two entries queued
      stepCycle(1, 1, 32'h40);
      for (int i = 0; i < 20 && modelQ.size() != 2; i++) begin
         stepCycle(1, 0, 32'd0);
      end
      @(posedge clk);
      #1;
      checkVal("t5_preValid", 32'(instr_valid), 32'd1);
      checkVal("t5_preReq", 32'(imem_req), 32'd1);
      checkVal("t5_prePcf", PCF, 32'h40);
      applyReset();
      waitNewReq("t5_resetAddr", 0, RESET_PC);

      // 6: PC wrap at the top of the address space
      stepCycle(1, 1, 32'hFFFF_FFFC);
      waitNewReq("t6_addrTop", 1, 32'hFFFF_FFFC);
      waitNewReq("t6_addrWrap", 1, 32'h0000_0000);
      checkVal("t6_pcf", PCF, 32'hFFFF_FFFC);
      checkVal("t6_pc4", PCPlus4F, 32'h0000_0000);
      for (int i = 0; i < 6; i++) begin
         stepCycle(0, 0, 32'd0);
      end

      // Randomized traffic
      latMin = 0;
      latMax = 3;
      for (int i = 0; i < 1500; i++) begin
         tgt  = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | ($urandom() & 32'hC))
                                             : ($urandom() & 32'hFFFF_FFFC);
         mode = 0;
         if ($urandom_range(99, 0) < 4) begin
            mode = 1;
         end else if ($urandom_range(99, 0) < 3) begin
            mode = 2;
         end
         stepCycle($urandom_range(99, 0) < 30, mode, tgt);
      end

      $display("%0d/%0d checks passed", passCnt, totalCnt);
      $finish;
   end

endmodule
